multipler_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one iterative multiplier (multipler_top) between NUM_REQ requesters.
- Each requester hands over an operand pair with a valid/ready handshake.
- The arbiter drives the multiplier's start/busy/finish protocol.
- The product goes back to the granted requester on a valid/ready response channel.
- Sits between client blocks and the single multiplier instance; the multiplier is reset by the same rst_ni.

---
 rtl/multipler_arbiter_if.sv | 43 ++++
 rtl/multipler_arbiter.sv | 109 ++++++++++
 tb/tb_multipler_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multipler_arbiter_if.sv
// Shared operand width and the signal bundle between the multiplier arbiter,
// its requesters and the single iterative multiplier.
package multipler_pkg;
  localparam int unsigned DATA_LENGTH = 32;
endpackage

interface multipler_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_LENGTH = multipler_pkg::DATA_LENGTH
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  // Requester side: operand slice k belongs to requester k.
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ-1:0][DATA_LENGTH-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_LENGTH-1:0] req_b;
  logic [NUM_REQ-1:0]                  rsp_valid;
  logic [NUM_REQ-1:0]                  rsp_ready;
  logic [2*DATA_LENGTH-1:0]            rsp_data;

  // Multiplier side.
  logic                                mul_start;
  logic                                mul_busy;
  logic                                mul_finish;
  logic [DATA_LENGTH-1:0]              mul_a;
  logic [DATA_LENGTH-1:0]              mul_b;
  logic [2*DATA_LENGTH-1:0]            mul_r;

  // Status.
  logic [ID_W-1:0]                     grant_id;
  logic                                busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_busy, mul_finish, mul_r,
    output req_ready, rsp_valid, rsp_data, mul_start, mul_a, mul_b, grant_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_busy, mul_finish, mul_r,
    input  req_ready, rsp_valid, rsp_data, mul_start, mul_a, mul_b, grant_id, busy
  );
endinterface

// File: rtl/multipler_arbiter.sv
// Round-robin arbiter that shares one iterative multiplier between NUM_REQ
// requesters; one operation in flight, product returned to the granted requester.
module multipler_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_LENGTH = multipler_pkg::DATA_LENGTH
) (
  input logic               clk_i,
  input logic               rst_ni,
  multipler_arbiter_if.slave bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic            unused_mul_busy;

  // Multiplier busy is informational only; finish alone ends an operation.
  assign unused_mul_busy = bus.mul_busy;

  // Scan from farthest to nearest so the requester closest after 'last' wins.
  always_comb begin
    winner = last;
    idx    = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      idx = ID_W'((int'(last) + i) % int'(NUM_REQ));
      if (bus.req_valid[idx]) begin
        winner = idx;
      end
    end
  end

  // Sequencer: grant, load operands, pulse start, wait for finish, return product.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      last          <= ID_W'(NUM_REQ - 1);
      bus.grant_id  <= '0;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.mul_start <= 1'b0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            bus.grant_id          <= winner;
            bus.req_ready         <= '0;
            bus.req_ready[winner] <= 1'b1;
            bus.busy              <= 1'b1;
            state                 <= LOAD;
          end
        end
        LOAD: begin
          bus.req_ready <= '0;
          if (bus.req_valid[bus.grant_id]) begin
            bus.mul_a     <= bus.req_a[bus.grant_id];
            bus.mul_b     <= bus.req_b[bus.grant_id];
            bus.mul_start <= 1'b1;
            state         <= START;
          end else begin
            // Requester withdrew before acceptance: abandon without touching the pointer.
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        START: begin
          bus.mul_start <= 1'b0;
          state         <= WAIT;
        end
        WAIT: begin
          if (bus.mul_finish) begin
            bus.rsp_data                <= bus.mul_r;
            bus.rsp_valid               <= '0;
            bus.rsp_valid[bus.grant_id] <= 1'b1;
            state                       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready[bus.grant_id]) begin
            bus.rsp_valid <= '0;
            last          <= bus.grant_id;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.req_ready <= '0;
          bus.rsp_valid <= '0;
          bus.mul_start <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multipler_arbiter.sv
// Randomised scoreboard bench for multipler_arbiter with a behavioural
// variable-latency multiplier and a round-robin reference model.
module tb_multipler_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  typedef logic [N-1:0] vec_t;
  typedef struct {
    int          k;
    logic [63:0] v;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  multipler_arbiter_if #(.NUM_REQ(N), .DATA_LENGTH(DW)) bus ();
  multipler_arbiter #(.NUM_REQ(N), .DATA_LENGTH(DW)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];
  int            grant_log[$];
  logic [DW-1:0] op_a[N];
  logic [DW-1:0] op_b[N];
  bit            accepted[N];
  bit            auto_re[N];
  bit            rand_mode = 1'b0;
  bit            rand_rdy  = 1'b0;
  int            issued_total = 0;
  int            done_cnt = 0;
  int            model_last = N - 1;
  bit            inflight = 1'b0;
  int            cur = 0;
  logic [DW-1:0] cur_a, cur_b;
  logic [63:0]   last_data = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference round robin: first valid requester after the last one served.
  function automatic int rr_pick(input int last, input vec_t v);
    for (int i = 1; i <= int'(N); i++) begin
      if (v[(last + i) % int'(N)]) return (last + i) % int'(N);
    end
    return -1;
  endfunction

  function automatic logic [63:0] exp_peek(input int k);
    foreach (exp_q[i]) if (exp_q[i].k == k) return exp_q[i].v;
    return 'x;
  endfunction

  function automatic void exp_drop(input int k);
    foreach (exp_q[i]) begin
      if (exp_q[i].k == k) begin
        exp_q.delete(i);
        return;
      end
    end
  endfunction

  function automatic logic [DW-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic issue(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    op_a[k]          = a;
    op_b[k]          = b;
    bus.req_a[k]     = a;
    bus.req_b[k]     = b;
    bus.req_valid[k] = 1'b1;
    e.k = k;
    e.v = 64'(a) * 64'(b);
    exp_q.push_back(e);
    issued_total++;
  endtask

  // Behavioural multiplier: random latency, one-cycle finish pulse.
  int            m_cnt;
  logic [DW-1:0] m_a, m_b;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.mul_busy   <= 1'b0;
      bus.mul_finish <= 1'b0;
      bus.mul_r      <= '0;
      m_cnt          <= 0;
      m_a            <= '0;
      m_b            <= '0;
    end else begin
      bus.mul_finish <= 1'b0;
      if (bus.mul_start && !bus.mul_busy) begin
        m_a          <= bus.mul_a;
        m_b          <= bus.mul_b;
        m_cnt        <= int'($urandom_range(1, 6));
        bus.mul_busy <= 1'b1;
      end else if (bus.mul_busy) begin
        if (m_cnt == 1) begin
          bus.mul_busy   <= 1'b0;
          bus.mul_finish <= 1'b1;
          bus.mul_r      <= 64'(m_a) * 64'(m_b);
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Requester driver: drop valid after acceptance, optional re-request and random traffic.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      for (int k = 0; k < int'(N); k++) begin
        if (accepted[k]) begin
          accepted[k]      = 1'b0;
          bus.req_valid[k] = 1'b0;
          if (auto_re[k]) issue(k, DW'($urandom), DW'($urandom));
        end else if (rand_mode && !bus.req_valid[k] && $urandom_range(0, 3) == 0) begin
          issue(k, rand_op(), rand_op());
        end
      end
      if (rand_rdy) bus.rsp_ready = vec_t'($urandom);
    end
  end

  // Monitor / scoreboard.
  vec_t        prev_valid = '0;
  bit          prev_ready_any = 1'b0;
  bit          prev_finish = 1'b0;
  bit          prev_rsp_any = 1'b0;
  bit          prev_hs = 1'b0;
  bit          prev_idle = 1'b0;
  logic [63:0] prev_data = '0;
  initial begin
    forever begin
      bit hs;
      bit rsp_first;
      bit idle_now;
      int k;
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_valid     = '0;
        prev_ready_any = 1'b0;
        prev_finish    = 1'b0;
        prev_rsp_any   = 1'b0;
        prev_hs        = 1'b0;
        prev_idle      = 1'b0;
        model_last     = N - 1;
        inflight       = 1'b0;
        exp_q.delete();
        for (int j = 0; j < int'(N); j++) accepted[j] = 1'b0;
        continue;
      end
      hs        = 1'b0;
      rsp_first = (|bus.rsp_valid) && !prev_rsp_any;
      idle_now  = !inflight && !(|bus.req_ready);
      k         = 0;

      if (prev_idle && (|prev_valid)) chk("ready_latency", 64'(|bus.req_ready), 64'(1));
      if (|bus.req_ready) begin
        for (int j = 0; j < int'(N); j++) if (bus.req_ready[j]) k = j;
        chk("ready_onehot", 64'($onehot(bus.req_ready)), 64'(1));
        chk("grant_order", 64'(k), 64'(rr_pick(model_last, prev_valid)));
        chk("grant_id", 64'(bus.grant_id), 64'(k));
        chk("ready_needs_valid", 64'(bus.req_valid[k]), 64'(1));
        chk("single_in_flight", 64'(inflight), 64'(0));
        cur         = k;
        cur_a       = op_a[k];
        cur_b       = op_b[k];
        accepted[k] = 1'b1;
        inflight    = 1'b1;
        grant_log.push_back(k);
      end

      if (bus.mul_start || prev_ready_any) chk("start_timing", 64'(bus.mul_start), 64'(prev_ready_any));
      if (bus.mul_start) begin
        chk("start_a", 64'(bus.mul_a), 64'(cur_a));
        chk("start_b", 64'(bus.mul_b), 64'(cur_b));
      end
      if (bus.mul_finish) chk("operand_hold", {bus.mul_a, bus.mul_b}, {cur_a, cur_b});

      if (rsp_first || prev_finish) chk("rsp_latency", 64'(rsp_first), 64'(prev_finish));
      if (prev_hs) chk("rsp_drop", 64'(bus.rsp_valid), 64'(0));
      if (prev_rsp_any && !prev_hs) chk("rsp_hold_valid", 64'(|bus.rsp_valid), 64'(1));
      if (|bus.rsp_valid) begin
        chk("rsp_vector", 64'(bus.rsp_valid), 64'(1) << cur);
        chk("quiet_in_resp", 64'({bus.req_ready, bus.mul_start}), 64'(0));
        if (rsp_first) chk("rsp_data", bus.rsp_data, exp_peek(cur));
        else           chk("rsp_hold_data", bus.rsp_data, prev_data);
        if (bus.rsp_ready[cur]) begin
          hs         = 1'b1;
          exp_drop(cur);
          last_data  = bus.rsp_data;
          model_last = cur;
          done_cnt++;
        end
      end

      chk("busy", 64'(bus.busy), 64'(inflight));
      if (hs) inflight = 1'b0;

      prev_valid     = bus.req_valid;
      prev_ready_any = |bus.req_ready;
      prev_finish    = bus.mul_finish;
      prev_rsp_any   = |bus.rsp_valid;
      prev_hs        = hs;
      prev_idle      = idle_now;
      prev_data      = bus.rsp_data;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_mul_start"}, 64'(bus.mul_start), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_grant_id"}, 64'(bus.grant_id), 64'(0));
    chk({tag, "_mul_a"}, 64'(bus.mul_a), 64'(0));
    chk({tag, "_mul_b"}, 64'(bus.mul_b), 64'(0));
    chk({tag, "_rsp_data"}, bus.rsp_data, 64'(0));
  endtask

  task automatic do_reset(input string tag, input int cycles);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs(tag);
    bus.req_valid = '0;
    for (int k = 0; k < int'(N); k++) auto_re[k] = 1'b0;
    repeat (cycles) @(posedge clk_i);
    #3;
    rst_ni       = 1'b1;
    issued_total = done_cnt;
  endtask

  task automatic wait_all(input string tag, input int budget);
    int n = 0;
    while ((done_cnt != issued_total || (|bus.req_valid)) && n < budget) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    chk({tag, "_completed_in_budget"}, 64'(n < budget), 64'(1));
  endtask

  task automatic check_log(input string tag, input int exp0, input int exp1, input int exp2, input int exp3, input int len);
    int exp_arr[4];
    exp_arr = '{exp0, exp1, exp2, exp3};
    chk({tag, "_grant_count"}, 64'(grant_log.size() >= len), 64'(1));
    if (grant_log.size() >= len)
      for (int i = 0; i < len; i++) chk({tag, "_grant_seq"}, 64'(grant_log[i]), 64'(exp_arr[i]));
  endtask

  // Stimulus.
  initial begin
    int n;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
    for (int k = 0; k < int'(N); k++) begin
      accepted[k] = 1'b0;
      auto_re[k]  = 1'b0;
    end
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("por");
    @(posedge clk_i);
    #3 rst_ni = 1'b1;

    // Single request from requester 2.
    @(posedge clk_i);
    #2;
    bus.rsp_ready = '1;
    grant_log.delete();
    issue(2, 32'h0000_1234, 32'h0000_0010);
    wait_all("t1", 200);
    chk("t1_product", last_data, 64'h0000_0000_0001_2340);
    check_log("t1", 2, 0, 0, 0, 1);

    // All four at once from a fresh pointer.
    do_reset("t2_rst", 1);
    @(posedge clk_i);
    #2;
    grant_log.delete();
    issue(0, 32'h0000_0003, 32'h0000_0007);
    issue(1, 32'h0001_0000, 32'h0001_0000);
    issue(2, 32'hDEAD_BEEF, 32'h0000_0002);
    issue(3, 32'h8000_0000, 32'h0000_0004);
    wait_all("t2", 400);
    check_log("t2", 0, 1, 2, 3, 4);

    // Requesters 0 and 2 requesting continuously.
    grant_log.delete();
    auto_re[0] = 1'b1;
    auto_re[2] = 1'b1;
    issue(0, DW'($urandom), DW'($urandom));
    issue(2, DW'($urandom), DW'($urandom));
    n = 0;
    while (grant_log.size() < 4 && n < 400) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    auto_re[0] = 1'b0;
    auto_re[2] = 1'b0;
    wait_all("t3", 400);
    check_log("t3", 0, 2, 0, 2, 4);
    foreach (grant_log[i]) chk("t3_only_0_2", 64'(grant_log[i] == 0 || grant_log[i] == 2), 64'(1));

    // Backpressure on requester 1 while requester 3 waits.
    bus.rsp_ready = 4'b1101;
    issue(1, 32'h1357_9BDF, 32'h0246_8ACE);
    n = 0;
    while (!bus.rsp_valid[1] && n < 200) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    chk("t4_rsp_seen", 64'(bus.rsp_valid[1]), 64'(1));
    issue(3, 32'h0000_0100, 32'h0000_0100);
    repeat (20) begin
      @(posedge clk_i);
      #2;
      chk("t4_hold_valid", 64'(bus.rsp_valid[1]), 64'(1));
      chk("t4_no_new_op", 64'({bus.req_ready, bus.mul_start}), 64'(0));
    end
    bus.rsp_ready[1] = 1'b1;
    wait_all("t4", 300);
    chk("t4_last_product", last_data, 64'h0000_0000_0001_0000);

    // Largest operands.
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_all("t5", 200);
    chk("t5_product", last_data, 64'hFFFF_FFFE_0000_0001);

    // Reset while the multiplier is working.
    issue(3, 32'h0BAD_F00D, 32'h0000_0011);
    n = 0;
    while (!bus.mul_start && n < 200) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    chk("t6_start_seen", 64'(bus.mul_start), 64'(1));
    do_reset("t6_rst", 2);
    @(posedge clk_i);
    #2;
    grant_log.delete();
    issue(3, 32'h0000_0005, 32'h0000_0006);
    issue(0, 32'h0000_0009, 32'h0000_000A);
    wait_all("t6", 300);
    check_log("t6", 0, 3, 0, 0, 2);

    // Random traffic with random response backpressure.
    n = done_cnt;
    grant_log.delete();
    rand_rdy  = 1'b1;
    rand_mode = 1'b1;
    repeat (800) @(posedge clk_i);
    rand_mode = 1'b0;
    wait_all("rand", 3000);
    chk("rand_activity", 64'((done_cnt - n) >= 20), 64'(1));
    rand_rdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
